// File: rtl/tick_stopwatch_pkg.sv
// Shared types and constants for the tick-driven mm:ss stopwatch.
package stopwatch_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  // One BCD digit
  typedef logic [3:0] bcd_t;

  // Wrap points of the fixed digits; the minute tens limit is a top-level parameter
  localparam bcd_t SEC_ONES_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_ONES_MAX = 4'd9;

endpackage

// File: rtl/tick_stopwatch_bcd_digit_counter.sv
// Single BCD digit that counts 0..MAX and produces a carry on the increment
// that wraps it back to 0. Carries are combinational so a whole chain of
// digits settles on the same clock edge.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc_in,
  output bcd_t digit,
  output logic carry_out
);

  bcd_t digit_q;
  bcd_t digit_d;
  logic at_max;

  assign at_max = (digit_q == MAX);

  // Next digit value: clear has priority over increment
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc_in) begin
      digit_d = at_max ? '0 : digit_q + 4'd1;
    end
  end

  // Digit register
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign carry_out = inc_in & at_max;

endmodule

// File: rtl/tick_stopwatch.sv
// mm:ss BCD stopwatch advanced by rising edges of a slow square wave that
// lives in the clk domain (used as data, never as a clock).
// Optional feature macro: LAP_HOLD_EN -- when defined, lap freezes the
// displayed digits on a snapshot while the internal count keeps going.
module tick_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_COUNT = 1,
  parameter int MAX_MIN_TENS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover
);

  localparam logic [7:0]  PRE_LAST  = 8'(TICKS_PER_COUNT - 1);
  localparam logic [15:0] DIGIT_MAX = {4'(MAX_MIN_TENS), MIN_ONES_MAX,
                                       SEC_TENS_MAX, SEC_ONES_MAX};

  sw_state_e  state_q;
  logic       running_q;
  logic       tick_q;
  logic       tick_rise;
  logic [7:0] pre_q;
  logic [7:0] pre_d;
  logic       count_en;
  logic       inc;
  logic       rollover_q;
  logic [4:0] carry;
  bcd_t       live [4];
  bcd_t       disp [4];

  // Delayed copy of tick_in for edge detection; resets high so a tick_in
  // already high at reset release is not seen as an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b1;
    end else begin
      tick_q <= tick_in;
    end
  end

  assign tick_rise = tick_in & ~tick_q;

  // Only edges seen in RUN (pre-transition state) advance the prescaler
  assign count_en = (state_q == RUN) & tick_rise & ~clear;
  assign inc      = count_en & (pre_q == PRE_LAST);

  // Prescaler next value: PAUSE simply holds it, clear zeroes it
  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (count_en) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 8'd1;
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Start/stop/clear control FSM with registered running flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else if (clear) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE: begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: begin
          state_q   <= PAUSE;
          running_q <= 1'b0;
        end
        PAUSE: begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Digit chain: each digit's carry is the next digit's increment
  assign carry[0] = inc;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      bcd_digit_counter #(
        .MAX(DIGIT_MAX[gi*4 +: 4])
      ) u_digit (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear),
        .inc_in   (carry[gi]),
        .digit    (live[gi]),
        .carry_out(carry[gi+1])
      );
    end
  endgenerate

  // Full wrap to 00:00 shows up as a single-cycle pulse alongside the new digits
  always_ff @(posedge clk) begin
    if (rst) begin
      rollover_q <= 1'b0;
    end else begin
      rollover_q <= carry[4];
    end
  end

`ifdef LAP_HOLD_EN
  logic hold_q;
  bcd_t snap_q [4];

  // Lap toggles the display hold and captures the live digits when entering hold
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        snap_q[i] <= '0;
      end
    end else if (clear) begin
      hold_q <= 1'b0;
    end else if (lap && (state_q != IDLE)) begin
      hold_q <= ~hold_q;
      if (!hold_q) begin
        for (int i = 0; i < 4; i++) begin
          snap_q[i] <= live[i];
        end
      end
    end
  end

  // Display mux: snapshot while held, live count otherwise
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      disp[i] = hold_q ? snap_q[i] : live[i];
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;

  // Display always shows the live count
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      disp[i] = live[i];
    end
  end
`endif

  assign sec_ones = disp[0];
  assign sec_tens = disp[1];
  assign min_ones = disp[2];
  assign min_tens = disp[3];
  assign running  = running_q;
  assign rollover = rollover_q;

endmodule
